// File: rtl/jstk_cond_pkg.sv
// Shared defaults and FSM encoding for the joystick axis conditioner.
package jstk_cond_pkg;

  localparam int DATA_W_DEF = 10;
  localparam int CENTER_DEF = 512;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEADBAND = 2'd1,
    FILTER   = 2'd2,
    SLEW     = 2'd3
  } state_e;

endpackage

// File: rtl/jstk_axis_conditioner_if.sv
// Sample-in / conditioned-out bundle between the SPI joystick front end and the steering stages.
interface jstk_axis_conditioner_if
  import jstk_cond_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] x_val;
  logic [DATA_W-1:0] y_val;
  logic              in_valid;
  logic [DATA_W-1:0] x_out;
  logic [DATA_W-1:0] y_out;
  logic              out_valid;
  logic              stale;

  modport master (
    output x_val, y_val, in_valid,
    input  x_out, y_out, out_valid, stale
  );

  modport slave (
    input  x_val, y_val, in_valid,
    output x_out, y_out, out_valid, stale
  );

endinterface

// File: rtl/jstk_axis_cond.sv
// One joystick axis: deadband, optional 4-tap average (JSTK_AVG_EN) and slew limiter.
// Each stage is stepped by enables from the shared top-level FSM.
module jstk_axis_cond
  import jstk_cond_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CENTER    = CENTER_DEF,
  parameter int DEADZONE  = 16,
  parameter int SLEW_STEP = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] val_i,
  input  logic              ld_raw_i,
  input  logic              ld_center_i,
  input  logic              db_en_i,
`ifdef JSTK_AVG_EN
  input  logic              avg_en_i,
`endif
  input  logic              slew_en_i,
  output logic [DATA_W-1:0] out_o
);

  localparam int                       SW   = DATA_W + 1;
  localparam logic [DATA_W-1:0]        CTR  = DATA_W'(CENTER);
  localparam logic signed [SW-1:0]     DZ   = SW'(DEADZONE);
  localparam logic signed [SW-1:0]     STEP = SW'(SLEW_STEP);

  function automatic logic [DATA_W-1:0] deadband(input logic [DATA_W-1:0] v);
    logic signed [SW-1:0] d;
    d = $signed({1'b0, v}) - $signed({1'b0, CTR});
    if ((d <= DZ) && (d >= -DZ)) begin
      return CTR;
    end else begin
      return v;
    end
  endfunction

  // Clamped step toward tgt; landing exactly on tgt when within reach prevents overshoot.
  function automatic logic [DATA_W-1:0] slew(input logic [DATA_W-1:0] cur,
                                             input logic [DATA_W-1:0] tgt);
    logic signed [SW-1:0] d;
    logic signed [SW-1:0] nxt;
    d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (d > STEP) begin
      nxt = $signed({1'b0, cur}) + STEP;
    end else if (d < -STEP) begin
      nxt = $signed({1'b0, cur}) - STEP;
    end else begin
      nxt = $signed({1'b0, tgt});
    end
    return nxt[DATA_W-1:0];
  endfunction

  logic [DATA_W-1:0] raw_q, raw_d;
  logic [DATA_W-1:0] tgt_q, tgt_d;
  logic [DATA_W-1:0] out_q, out_d;

`ifdef JSTK_AVG_EN
  localparam int                SUM_W   = DATA_W + 2;
  localparam logic [SUM_W-1:0]  SUM_RST = SUM_W'(4 * CENTER);

  logic [DATA_W-1:0] tap_q [4];
  logic [DATA_W-1:0] tap_d [4];
  logic [SUM_W-1:0]  sum_q, sum_d;

  // Running sum: drop the oldest tap, add the deadbanded sample.
  always_comb begin
    tap_d = tap_q;
    sum_d = sum_q;
    if (avg_en_i) begin
      tap_d[0] = tgt_q;
      tap_d[1] = tap_q[0];
      tap_d[2] = tap_q[1];
      tap_d[3] = tap_q[2];
      sum_d    = sum_q - {2'b00, tap_q[3]} + {2'b00, tgt_q};
    end else begin
      tap_d = tap_q;
      sum_d = sum_q;
    end
  end

  // Averaging buffer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap_q <= '{CTR, CTR, CTR, CTR};
      sum_q <= SUM_RST;
    end else begin
      tap_q <= tap_d;
      sum_q <= sum_d;
    end
  end
`endif

  // tgt carries the deadband result, then the average, then feeds the slew stage.
  always_comb begin
    raw_d = raw_q;
    tgt_d = tgt_q;
    out_d = out_q;
    if (ld_raw_i) begin
      raw_d = val_i;
    end else begin
      raw_d = raw_q;
    end
    if (ld_center_i) begin
      tgt_d = CTR;
    end else if (db_en_i) begin
      tgt_d = deadband(raw_q);
`ifdef JSTK_AVG_EN
    end else if (avg_en_i) begin
      tgt_d = sum_d[SUM_W-1:2];
`endif
    end else begin
      tgt_d = tgt_q;
    end
    if (slew_en_i) begin
      out_d = slew(out_q, tgt_q);
    end else begin
      out_d = out_q;
    end
  end

  // Pipeline and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw_q <= CTR;
      tgt_q <= CTR;
      out_q <= CTR;
    end else begin
      raw_q <= raw_d;
      tgt_q <= tgt_d;
      out_q <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/jstk_axis_conditioner.sv
// Two-axis joystick conditioner: shared FSM sequencing two jstk_axis_cond lanes plus idle timeout.
// Define JSTK_AVG_EN to include the FILTER stage and averaging buffer (latency 3 instead of 2).
module jstk_axis_conditioner
  import jstk_cond_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int CENTER      = CENTER_DEF,
  parameter int DEADZONE    = 16,
  parameter int SLEW_STEP   = 8,
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  jstk_axis_conditioner_if.slave  bus
);

  localparam int               CNT_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stale_q, stale_d;
  logic             out_valid_q, out_valid_d;
  logic             accept_s, wrap_s;
  logic             ld_raw_s, ld_center_s, db_en_s, slew_en_s;
`ifdef JSTK_AVG_EN
  logic             avg_en_s;
`endif

  // Next state, idle counter and stage enables; a sample beats a simultaneous timeout.
  always_comb begin
    accept_s    = bus.in_valid && (state_q == IDLE);
    wrap_s      = (cnt_q == CNT_MAX);
    state_d     = state_q;
    stale_d     = stale_q;
    out_valid_d = 1'b0;
    ld_raw_s    = 1'b0;
    ld_center_s = 1'b0;
    db_en_s     = 1'b0;
    slew_en_s   = 1'b0;
`ifdef JSTK_AVG_EN
    avg_en_s    = 1'b0;
`endif
    if (accept_s || wrap_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          ld_raw_s = 1'b1;
          stale_d  = 1'b0;
          state_d  = DEADBAND;
        end else if (wrap_s) begin
          ld_center_s = 1'b1;
          stale_d     = 1'b1;
          state_d     = SLEW;
        end else begin
          state_d = IDLE;
        end
      end
      DEADBAND: begin
        db_en_s = 1'b1;
`ifdef JSTK_AVG_EN
        state_d = FILTER;
`else
        state_d = SLEW;
`endif
      end
      FILTER: begin
`ifdef JSTK_AVG_EN
        avg_en_s = 1'b1;
        state_d  = SLEW;
`else
        state_d  = IDLE;
`endif
      end
      SLEW: begin
        slew_en_s   = 1'b1;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      stale_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stale_q     <= stale_d;
      out_valid_q <= out_valid_d;
    end
  end

  jstk_axis_cond #(
    .DATA_W(DATA_W), .CENTER(CENTER), .DEADZONE(DEADZONE), .SLEW_STEP(SLEW_STEP)
  ) u_x (
    .clk(clk), .rst(rst), .val_i(bus.x_val),
    .ld_raw_i(ld_raw_s), .ld_center_i(ld_center_s), .db_en_i(db_en_s),
`ifdef JSTK_AVG_EN
    .avg_en_i(avg_en_s),
`endif
    .slew_en_i(slew_en_s), .out_o(bus.x_out)
  );

  jstk_axis_cond #(
    .DATA_W(DATA_W), .CENTER(CENTER), .DEADZONE(DEADZONE), .SLEW_STEP(SLEW_STEP)
  ) u_y (
    .clk(clk), .rst(rst), .val_i(bus.y_val),
    .ld_raw_i(ld_raw_s), .ld_center_i(ld_center_s), .db_en_i(db_en_s),
`ifdef JSTK_AVG_EN
    .avg_en_i(avg_en_s),
`endif
    .slew_en_i(slew_en_s), .out_o(bus.y_out)
  );

  assign bus.out_valid = out_valid_q;
  assign bus.stale     = stale_q;

endmodule

// File: tb/tb_jstk_axis_conditioner.sv
// Scoreboard bench for jstk_axis_conditioner: a behavioural model pushes expected outputs on stimulus,
// a negedge monitor pops and compares them (values and latency) on every out_valid.
module tb_jstk_axis_conditioner;

  localparam int DW   = 10;
  localparam int CTR  = 512;
  localparam int DZ   = 16;
  localparam int STEP = 8;
  localparam int TO   = 100;
`ifdef JSTK_AVG_EN
  localparam int LAT  = 3;
`else
  localparam int LAT  = 2;
`endif

  typedef struct {
    int x;
    int y;
    int at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_ov = 0;
  int   last_acc = 0;
  int   last_at = 0;
  exp_t sb_q[$];
  int   m_out [2];
  int   m_tap [2][4];

  jstk_axis_conditioner_if #(.DATA_W(DW)) bus ();

  jstk_axis_conditioner #(
    .DATA_W(DW), .CENTER(CTR), .DEADZONE(DZ), .SLEW_STEP(STEP), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int m_slew(input int cur, input int tgt);
    int d;
    d = tgt - cur;
    if (d > STEP) return cur + STEP;
    if (d < -STEP) return cur - STEP;
    return tgt;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 2; a++) begin
      m_out[a] = CTR;
      for (int i = 0; i < 4; i++) m_tap[a][i] = CTR;
    end
    sb_q.delete();
  endtask

  task automatic model_axis(input int a, input int v);
    int t;
    t = ((v - CTR) <= DZ && (CTR - v) <= DZ) ? CTR : v;
`ifdef JSTK_AVG_EN
    for (int i = 3; i > 0; i--) m_tap[a][i] = m_tap[a][i-1];
    m_tap[a][0] = t;
    t = (m_tap[a][0] + m_tap[a][1] + m_tap[a][2] + m_tap[a][3]) / 4;
`endif
    m_out[a] = m_slew(m_out[a], t);
  endtask

  task automatic push_sample(input int x, input int y);
    exp_t e;
    model_axis(0, x);
    model_axis(1, y);
    e.x = m_out[0];
    e.y = m_out[1];
    e.at = cyc + 1 + LAT;
    sb_q.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int x, input int y);
    bus.x_val = DW'(x);
    bus.y_val = DW'(y);
    bus.in_valid = 1'b1;
    push_sample(x, y);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    last_acc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: every out_valid must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid === 1'b1) begin
      n_ov++;
      if (sb_q.size() == 0) begin
        check_eq("spurious_out_valid", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check_eq("x_out", int'(bus.x_out), e.x);
        check_eq("y_out", int'(bus.y_out), e.y);
        check_eq("out_latency", cyc, e.at);
      end
    end
  end

  initial begin
    int k;
    int ov0;
    exp_t e;
    bus.x_val = '0;
    bus.y_val = '0;
    bus.in_valid = 1'b0;
    model_reset();
    idle(3);
    check_eq("rst_x_out", int'(bus.x_out), CTR);
    check_eq("rst_y_out", int'(bus.y_out), CTR);
    check_eq("rst_out_valid", int'(bus.out_valid), 0);
    check_eq("rst_stale", int'(bus.stale), 0);
    rst = 1'b1;
    idle(1);

    // Full-scale X, zero Y from reset.
    send(1023, 0);
    idle(LAT + 2);
    check_eq("first_x_520", int'(bus.x_out), 520);
    check_eq("first_y_504", int'(bus.y_out), 504);
    check_eq("no_stale_yet", int'(bus.stale), 0);

    // Reset while the sample sits in DEADBAND: abandoned, outputs back to centre.
    bus.x_val = 10'd1023;
    bus.y_val = 10'd0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_eq("midrst_x_out", int'(bus.x_out), CTR);
    check_eq("midrst_y_out", int'(bus.y_out), CTR);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle(10);
    check_eq("midrst_no_ov", int'(bus.out_valid), 0);

    // Inside the deadzone, including the +/-DEADZONE edges.
    for (int i = 0; i < 3; i++) begin
      send(520, 500);
      idle(6);
      check_eq("dz_x_center", int'(bus.x_out), CTR);
      check_eq("dz_y_center", int'(bus.y_out), CTR);
    end
    send(528, 496);
    idle(6);
    check_eq("dz_edge_x", int'(bus.x_out), CTR);
    send(529, 495);
    idle(6);

    // Ramp to full scale in SLEW_STEP increments.
    for (int i = 0; i < 80; i++) begin
      send(1023, 512);
      idle(16);
    end
    check_eq("ramp_settle_1023", int'(bus.x_out), 1023);

    // Second strobe one cycle after an accept is dropped.
    ov0 = n_ov;
    bus.x_val = 10'd0;
    bus.y_val = 10'd0;
    bus.in_valid = 1'b1;
    push_sample(0, 0);
    @(posedge clk); #1;
    last_acc = cyc;
    bus.x_val = 10'd300;
    bus.y_val = 10'd900;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    idle(8);
    check_eq("drop_one_ov", n_ov - ov0, 1);

    // No more samples: stale, synthetic steps toward centre every TO cycles.
    k = 0;
    while (m_out[0] != CTR || m_out[1] != CTR || k < 2) begin
      m_out[0] = m_slew(m_out[0], CTR);
      m_out[1] = m_slew(m_out[1], CTR);
      e.x = m_out[0];
      e.y = m_out[1];
      e.at = last_acc + TO + 1 + k * TO;
      sb_q.push_back(e);
      last_at = e.at;
      k++;
    end
    wait_cyc(last_acc + TO - 1);
    check_eq("stale_before_timeout", int'(bus.stale), 0);
    wait_cyc(last_acc + TO);
    check_eq("stale_at_timeout", int'(bus.stale), 1);
    wait_cyc(last_at + 1);
    check_eq("synth_drained", sb_q.size(), 0);
    check_eq("synth_x_center", int'(bus.x_out), CTR);
    check_eq("stale_held", int'(bus.stale), 1);

    // Synthetic updates left the averaging buffer alone; accept clears stale.
    send(600, 512);
    check_eq("stale_cleared", int'(bus.stale), 0);
    idle(LAT + 2);

    // Sample arriving on the wrap edge wins over the synthetic update.
    wait_cyc(last_acc + TO - 1);
    send(100, 900);
    check_eq("wrap_sample_no_stale", int'(bus.stale), 0);
    idle(LAT + 3);
    check_eq("wrap_no_stale_after", int'(bus.stale), 0);
    check_eq("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jstk_axis_conditioner.md
JSTK_AXIS_CONDITIONER -- requirements
Module: jstk_axis_conditioner

Interface
REQ-001 Parameter DATA_W, default 10, width of joystick axis values.
REQ-002 Parameter CENTER, default 512, neutral axis value.
REQ-003 Parameter DEADZONE, default 16, half-width of the neutral band.
REQ-004 Parameter SLEW_STEP, default 8, maximum output change per update.
REQ-005 Parameter TIMEOUT_CYC, default 10_000_000, idle cycles before a stale update.
REQ-006 Port clk, input, 1, system clock; one clock domain, all logic on its rising edge.
REQ-007 Port rst, input, 1, asynchronous active-low reset.
REQ-008 Port x_val, input, DATA_W, raw X sample from the SPI joystick interface.
REQ-009 Port y_val, input, DATA_W, raw Y sample from the SPI joystick interface.
REQ-010 Port in_valid, input, 1, one-cycle strobe: x_val/y_val are a new sample pair.
REQ-011 Port x_out, output, DATA_W, conditioned X value, consumed by the X steering stage.
REQ-012 Port y_out, output, DATA_W, conditioned Y value, consumed by the Y steering stage.
REQ-013 Port out_valid, output, 1, one-cycle pulse when x_out/y_out update.
REQ-014 Port stale, output, 1, high while no sample has arrived within TIMEOUT_CYC.

Function
REQ-015 FSM states: IDLE, DEADBAND, FILTER, SLEW; IDLE->DEADBAND on accept, then one state per cycle, SLEW->IDLE.
REQ-016 in_valid is accepted only in IDLE; strobes in any other state are dropped without side effects.
REQ-017 DEADBAND: a value with |val-CENTER| <= DEADZONE is replaced by CENTER; otherwise it passes unchanged.
REQ-018 FILTER: 4-tap moving average per axis; running sum is DATA_W+2 bits; result = sum>>2, truncated.
REQ-019 SLEW: target minus current output is computed signed at DATA_W+1 bits; output moves by the difference clamped to ±SLEW_STEP.
REQ-020 out_valid pulses, with x_out/y_out updated, exactly 3 cycles after the accepted in_valid.
REQ-021 Idle counter: reset on accept; otherwise increments and wraps at TIMEOUT_CYC-1.
REQ-022 On counter wrap in IDLE: stale=1; run a synthetic update (target=CENTER on both axes, skips DEADBAND/FILTER); out_valid 1 cycle later.
REQ-023 Synthetic updates do not write the averaging buffer.
REQ-024 stale clears in the cycle after the next accepted in_valid.
REQ-025 in_valid in the same cycle as counter wrap: the sample wins; no synthetic update; counter resets.
REQ-026 Outputs stay within 0..2^DATA_W-1; slewing cannot overshoot the target.

Reset
REQ-027 Asynchronous reset: FSM=IDLE, x_out=y_out=CENTER, out_valid=0, stale=0, counter=0.
REQ-028 Asynchronous reset: every averaging tap=CENTER, each sum=4*CENTER.
REQ-029 Reset mid-operation abandons the sample in flight; no out_valid follows.

Configuration
REQ-030 Macro JSTK_AVG_EN defined: FILTER state and averaging buffer present; sample latency is 3 cycles.
REQ-031 Macro JSTK_AVG_EN undefined: FILTER omitted, DEADBAND feeds SLEW directly, sample latency is 2 cycles; other behaviour unchanged.

Structure
REQ-032 Package jstk_cond_pkg holds the DATA_W default, the CENTER default and the FSM state enum typedef.
REQ-033 Sub-module jstk_axis_cond implements deadband, average and slew for one axis; instantiated twice, sequenced by the shared top-level FSM.

Verification
REQ-034 After reset, in_valid with x=1023, y=0 -> out_valid at +3 cycles, x_out=520, y_out=504.
REQ-035 Samples x=520, y=500 (inside deadzone) -> x_out=y_out=512 unchanged on every out_valid.
REQ-036 Repeated x=1023 every 20 cycles -> x_out rises by 8 per update and settles at 1023 with no overshoot.
REQ-037 in_valid again 1 cycle after an accept -> second strobe dropped; exactly one out_valid.
REQ-038 TIMEOUT_CYC=100, no samples after x_out=600 -> stale=1; x_out steps 592, 584, ... every 100 cycles to 512.
REQ-039 rst low in DEADBAND state -> outputs read 512 immediately; no out_valid after release.
